// File: rtl/hypot_pkg.sv
// Shared definitions for the hypotenuse unit: FSM encodings, default ALU opcodes
// and the square-root iteration count.
package hypot_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SQ_A = 3'd1;
    localparam state_t ST_SQ_B = 3'd2;
    localparam state_t ST_SUM  = 3'd3;
    localparam state_t ST_SQRT = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    localparam logic [2:0] OP_ADD_DEF = 3'b000;
    localparam logic [2:0] OP_SUB_DEF = 3'b100;

    function automatic int sqrt_iters(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring digit-by-digit square root of a 2W+1-bit radicand; the subtraction
// x - (y | m) is issued on the shared ALU each cycle, the compare is local.
module isqrt_seq
    import hypot_pkg::*;
#(
    parameter int W     = 8,
    parameter int ALU_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [ALU_W-1:0] x_i,
    input  logic [ALU_W-1:0] alu_res_i,
    output logic [ALU_W-1:0] alu_a_o,
    output logic [ALU_W-1:0] alu_b_o,
    output logic             done_o,
    output logic [W:0]       root_o
);

    localparam int RW = 2 * W + 1;

    logic [ALU_W-1:0] x;
    logic [RW-1:0]    y;
    logic [RW-1:0]    m;
    logic [RW-1:0]    t;
    logic [RW-1:0]    y_next;
    logic             active;
    logic             x_ge;

    assign t      = y | m;
    assign x_ge   = x >= ALU_W'(t);
    assign y_next = x_ge ? ((y >> 1) | m) : (y >> 1);

    assign alu_a_o = x;
    assign alu_b_o = ALU_W'(t);
    // m has walked down to bit 0: this cycle produces the final root bit.
    assign done_o  = active & m[0];
    assign root_o  = y_next[W:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x      <= '0;
            y      <= '0;
            m      <= '0;
            active <= 1'b0;
        end else if (start_i) begin
            x      <= x_i;
            y      <= '0;
            m      <= RW'(1) << (2 * W);
            active <= 1'b1;
        end else if (active) begin
            if (x_ge) begin
                x <= alu_res_i;
            end
            y <= y_next;
            m <= m >> 2;
            if (m[0]) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hypot_shared_alu.sv
// floor(sqrt(a^2 + b^2)) or a^2 + b^2 computed one operation per cycle on an
// external shared combinational ALU, with valid/ready on input and output.
module hypot_shared_alu
    import hypot_pkg::*;
#(
    parameter int         W      = 8,
    parameter int         ALU_W  = 32,
    parameter logic [2:0] OP_ADD = OP_ADD_DEF,
    parameter logic [2:0] OP_SUB = OP_SUB_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mode_i,
    input  logic [W-1:0]     a_bi,
    input  logic [W-1:0]     b_bi,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*W:0]     res_bo,
    output logic             busy_o,
    output logic [2:0]       alu_op_o,
    output logic [ALU_W-1:0] alu_a_o,
    output logic [ALU_W-1:0] alu_b_o,
    input  logic [ALU_W-1:0] alu_res_i
);

    localparam int RW = 2 * W + 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(W - 1);

    if (ALU_W < RW) begin : g_alu_w_check
        $error("hypot_shared_alu: ALU_W must be at least 2*W+1");
    end

    state_t           state;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             mode_r;
    logic [ALU_W-1:0] acc;
    logic [ALU_W-1:0] sq_a;
    logic [IW-1:0]    i;
    logic [RW-1:0]    res;

    logic [W-1:0]     cur;
    logic [ALU_W-1:0] pp;
    logic             sq_start;
    logic             sq_done;
    logic [W:0]       sq_root;
    logic [ALU_W-1:0] sq_alu_a;
    logic [ALU_W-1:0] sq_alu_b;

    // Shift-add partial product: operand gated by its own bit i, weighted by 2^i.
    assign cur      = (state == ST_SQ_A) ? a_r : b_r;
    assign pp       = ALU_W'(cur & {W{cur[i]}}) << i;
    assign sq_start = (state == ST_SUM) && !mode_r;

    isqrt_seq #(
        .W     (W),
        .ALU_W (ALU_W)
    ) u_isqrt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (sq_start),
        .x_i       (alu_res_i),
        .alu_res_i (alu_res_i),
        .alu_a_o   (sq_alu_a),
        .alu_b_o   (sq_alu_b),
        .done_o    (sq_done),
        .root_o    (sq_root)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        alu_op_o = OP_ADD;
        alu_a_o  = '0;
        alu_b_o  = '0;
        case (state)
            ST_SQ_A, ST_SQ_B: begin
                alu_a_o = acc;
                alu_b_o = pp;
            end
            ST_SUM: begin
                alu_a_o = sq_a;
                alu_b_o = acc;
            end
            ST_SQRT: begin
                alu_op_o = OP_SUB;
                alu_a_o  = sq_alu_a;
                alu_b_o  = sq_alu_b;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            acc    <= '0;
            sq_a   <= '0;
            i      <= '0;
            res    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        a_r    <= a_bi;
                        b_r    <= b_bi;
                        mode_r <= mode_i;
                        acc    <= '0;
                        sq_a   <= '0;
                        i      <= '0;
                        state  <= ST_SQ_A;
                    end
                end
                ST_SQ_A, ST_SQ_B: begin
                    if (i == I_LAST) begin
                        i <= '0;
                        if (state == ST_SQ_A) begin
                            sq_a  <= alu_res_i;
                            acc   <= '0;
                            state <= ST_SQ_B;
                        end else begin
                            acc   <= alu_res_i;
                            state <= ST_SUM;
                        end
                    end else begin
                        acc <= alu_res_i;
                        i   <= i + IW'(1);
                    end
                end
                ST_SUM: begin
                    if (mode_r) begin
                        res   <= alu_res_i[RW-1:0];
                        state <= ST_DONE;
                    end else begin
                        state <= ST_SQRT;
                    end
                end
                ST_SQRT: begin
                    if (sq_done) begin
                        res   <= RW'(sq_root);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign out_valid_o = (state == ST_DONE);
    assign res_bo      = res;

endmodule
